dot_feeder: RTL
===============

// Module: dot_feeder
// PURPOSE
//  Operand-side driver and result collector for the 8-lane signed dot-product core (baseline).
//  - Packs a serial (a,b) element stream into 8-lane operand vectors and holds them stable on the core.
//  - Waits the core latency, then reduces the core's two partial sums into one result.
//  - Presents that result on a valid/ready output. Sits between the operand fetch stream and the core.
// PARAMETERS
//  IN_SIZE_0  4  signed width of operand a (core in_0)
//  IN_SIZE_1  8  signed width of operand b (core in_1)
//  CORE_LAT   3  rising edges from operand update to core_out_i valid (>=1)
//  OUT_SIZE   IN_SIZE_0+IN_SIZE_1+4  localparam; result/partial width
// PORTS
//  clk_i          in   1                    clock
//  rst_ni         in   1                    async reset, active-low
//  s_valid_i      in   1                    element valid
//  s_ready_o      out  1                    element accepted when s_valid_i&&s_ready_o
//  s_a_i          in   IN_SIZE_0            signed operand a
//  s_b_i          in   IN_SIZE_1            signed operand b
//  s_last_i       in   1                    element closes vector (short vector / group end)
//  core_in_0_o    out  8 x IN_SIZE_0        lane operands a to core
//  core_in_1_o    out  8 x IN_SIZE_1        lane operands b to core
//  core_out_i     in   2 x OUT_SIZE         core partial sums
//  m_valid_o      out  1                    result valid
//  m_ready_i      in   1                    result consumed when m_valid_o&&m_ready_i
//  m_data_o       out  OUT_SIZE             signed result
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=FILL; lane count=0; all core_in lanes=0; m_valid_o=0; m_data_o=0; acc=0.
//    s_ready_o=(state==FILL), so it reads 1 under reset. Reset mid-operation aborts the vector silently.
//  - FILL: s_ready_o=1. Each handshake writes lane[cnt], cnt++.
//    Vector closes on the handshake with cnt==7 or s_last_i=1. On a short vector, lanes cnt+1..7 are
//    written to 0 on the same edge. Next state is WAIT with wait counter=CORE_LAT.
//  - WAIT: s_ready_o=0; s_valid_i is ignored; core_in lanes are held stable; counter decrements each edge.
//    On the CORE_LAT-th edge after the closing edge, sample sum=$signed(core_out_i[0])+$signed(core_out_i[1]).
//    Sum is computed at OUT_SIZE bits; no overflow is possible. Register it into m_data_o, go to OUT.
//    m_valid_o rises the cycle after that edge.
//  - OUT: m_valid_o=1; m_data_o is stable while m_ready_i=0; s_ready_o=0.
//    On handshake: m_valid_o=0, cnt=0, go to FILL. m_data_o keeps its last value.
//  - Minimum period per vector: 8 + CORE_LAT + 1 cycles with m_ready_i tied high.
//  - core_in lanes change only on FILL handshakes; the last vector's lanes remain on the core while idle.
// CONFIGURATION
//  DOT_FEEDER_ACC_EN
//  - Defined: signed acc (OUT_SIZE) sums vector results across a group.
//    - End of WAIT with no s_last_i seen: acc=sat(acc+sum), go to FILL (no output).
//    - End of WAIT with s_last_i seen: m_data_o=sat(acc+sum), acc=0, go to OUT.
//    - sat() clamps to OUT_SIZE signed max/min.
//  - Undefined: every closed vector emits one result; s_last_i only closes short vectors; no acc register.
// STRUCTURE
//  - dot_feeder_pkg: state enum {FILL,WAIT,OUT}; LANES=8 constant; sat_add function (used under ACC_EN).
//  - Sub-module dot_lane_buf: 8-lane a/b register file with indexed write and zero-pad-above-index.
//  - FSM, latency counter and reduction stay in dot_feeder.
// TESTING (bench connects baseline as core, CORE_LAT=3)
//  1 8 elems a=1,b=2 -> m_data_o=16; m_valid_o high 4 cycles after closing handshake; s_ready_o=0 until consumed.
//  2 8 elems a=-8,b=-128 -> 8192; then a=7,b=-128 -> -7168 (sign and corner check).
//  3 3 elems a=7,b=127, s_last_i on 3rd -> 2667; core lanes 3..7 read 0 during WAIT.
//  4 m_ready_i low 5 cycles in OUT -> m_data_o stable, m_valid_o=1, s_ready_o=0, no element accepted.
//  5 rst_ni pulsed low in WAIT -> m_valid_o=0, lanes=0, s_ready_o=1; next vector a=1,b=1 -> 8.
//  6 ACC_EN: full a=1,b=1; full a=1,b=1; 1 elem a=-1,b=1 +last -> single result 15 (undefined: 8,8,-1).

Source files
------------

// File: rtl/dot_feeder_pkg.sv
// dot_feeder_pkg
//   Shared types and constants for the dot-product operand feeder.
//   - stateT   : feeder FSM states (FILL, WAIT, OUT)
//   - LANES    : number of lanes presented to the dot-product core
//   - sat_add  : saturating signed add, used only when DOT_FEEDER_ACC_EN is defined
package dot_feeder_pkg;

    localparam int LANES      = 8;
    localparam int LANE_IDX_W = 3;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } stateT;

    // Adds two sign-extended values and clamps the result to the signed
    // range of a 'width'-bit number; the caller truncates back to width.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                   input logic signed [63:0] y,
                                                   input int              width);
        logic signed [63:0] sum;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        sum  = x + y;
        maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
        minV = -maxV - 64'sd1;
        if (sum > maxV) begin
            return maxV;
        end
        if (sum < minV) begin
            return minV;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dot_feeder_if.sv
// dot_feeder_if
//   Element stream (s_*) into the feeder and result stream (m_*) out of it.
//   - s_valid_i/s_ready_o : element handshake
//   - s_a_i, s_b_i        : signed operands a and b
//   - s_last_i            : element closes the current vector / group
//   - m_valid_o/m_ready_i : result handshake
//   - m_data_o            : signed result
//   Modports: slave = the feeder, master = the element source / result sink.
interface dot_feeder_if #(
    parameter  int IN_SIZE_0 = 4,
    parameter  int IN_SIZE_1 = 8,
    localparam int OUT_SIZE  = IN_SIZE_0 + IN_SIZE_1 + 4
);

    logic                        s_valid_i;
    logic                        s_ready_o;
    logic signed [IN_SIZE_0-1:0] s_a_i;
    logic signed [IN_SIZE_1-1:0] s_b_i;
    logic                        s_last_i;
    logic                        m_valid_o;
    logic                        m_ready_i;
    logic signed [OUT_SIZE-1:0]  m_data_o;

    modport slave (
        input  s_valid_i, s_a_i, s_b_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o
    );

    modport master (
        output s_valid_i, s_a_i, s_b_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o
    );

endinterface

// File: rtl/dot_feeder_lane_buf.sv
// dot_lane_buf
//   8-lane a/b operand register file driving the dot-product core.
//   - clk_i, rst_ni        : clock, async active-low reset (all lanes to 0)
//   - wrEn_i, wrIdx_i      : write lane wrIdx_i with wrA_i/wrB_i
//   - padAbove_i           : on the same write, clear every lane above wrIdx_i
//   - lanesA_o, lanesB_o   : lane contents, held until the next write
module dot_lane_buf
    import dot_feeder_pkg::*;
#(
    parameter int A_W = 4,
    parameter int B_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wrEn_i,
    input  logic [LANE_IDX_W-1:0]        wrIdx_i,
    input  logic [A_W-1:0]               wrA_i,
    input  logic [B_W-1:0]               wrB_i,
    input  logic                         padAbove_i,
    output logic [LANES-1:0][A_W-1:0]    lanesA_o,
    output logic [LANES-1:0][B_W-1:0]    lanesB_o
);

    // Lanes only move on a write; a short vector zero-pads the unused upper
    // lanes in the same edge so the core never sees stale operands there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanesA_o <= '0;
            lanesB_o <= '0;
        end else if (wrEn_i) begin
            for (int j = 0; j < LANES; j++) begin
                if (j == int'(wrIdx_i)) begin
                    lanesA_o[j] <= wrA_i;
                    lanesB_o[j] <= wrB_i;
                end else if (padAbove_i && (j > int'(wrIdx_i))) begin
                    lanesA_o[j] <= '0;
                    lanesB_o[j] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/dot_feeder.sv
// dot_feeder
//   Packs a serial (a,b) element stream into 8-lane operand vectors for the
//   dot-product core, waits CORE_LAT edges, adds the core's two partial sums
//   and offers the result on a valid/ready output.
//   - clk_i, rst_ni      : clock, async active-low reset
//   - bus (slave)        : element stream in, result stream out
//   - core_in_0_o/1_o    : lane operands a/b to the core
//   - core_out_i         : the core's two partial sums
//   Optional macro DOT_FEEDER_ACC_EN: accumulate vector results across a
//   group closed by s_last_i, with saturation, emitting one result per group.
module dot_feeder
    import dot_feeder_pkg::*;
#(
    parameter  int IN_SIZE_0 = 4,
    parameter  int IN_SIZE_1 = 8,
    parameter  int CORE_LAT  = 3,
    localparam int OUT_SIZE  = IN_SIZE_0 + IN_SIZE_1 + 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    dot_feeder_if.slave                      bus,
    output logic [LANES-1:0][IN_SIZE_0-1:0]  core_in_0_o,
    output logic [LANES-1:0][IN_SIZE_1-1:0]  core_in_1_o,
    input  logic [1:0][OUT_SIZE-1:0]         core_out_i
);

    localparam int CW = $clog2(CORE_LAT + 1);

    stateT                      state_q, state_d;
    logic [LANE_IDX_W-1:0]      laneCnt_q, laneCnt_d;
    logic [CW-1:0]              waitCnt_q, waitCnt_d;
    logic signed [OUT_SIZE-1:0] mData_q, mData_d;
    logic                       accepted;
    logic                       closing;
    logic signed [OUT_SIZE-1:0] sumW;
`ifdef DOT_FEEDER_ACC_EN
    logic                       lastSeen_q, lastSeen_d;
    logic signed [OUT_SIZE-1:0] acc_q, acc_d;
    logic signed [OUT_SIZE-1:0] accSum;
`endif

    assign bus.s_ready_o = (state_q == FILL);
    assign bus.m_valid_o = (state_q == OUT);
    assign bus.m_data_o  = mData_q;

    assign accepted = bus.s_valid_i && bus.s_ready_o;
    assign closing  = accepted && ((laneCnt_q == LANE_IDX_W'(LANES - 1)) || bus.s_last_i);
    assign sumW     = $signed(core_out_i[0]) + $signed(core_out_i[1]);

`ifdef DOT_FEEDER_ACC_EN
    assign accSum = OUT_SIZE'(sat_add(64'(acc_q), 64'(sumW), OUT_SIZE));
`endif

    dot_lane_buf #(
        .A_W (IN_SIZE_0),
        .B_W (IN_SIZE_1)
    ) u_lane_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wrEn_i     (accepted),
        .wrIdx_i    (laneCnt_q),
        .wrA_i      (bus.s_a_i),
        .wrB_i      (bus.s_b_i),
        .padAbove_i (closing),
        .lanesA_o   (core_in_0_o),
        .lanesB_o   (core_in_1_o)
    );

    // All feeder state; reset silently abandons any vector in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FILL;
            laneCnt_q  <= '0;
            waitCnt_q  <= '0;
            mData_q    <= '0;
`ifdef DOT_FEEDER_ACC_EN
            lastSeen_q <= 1'b0;
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            laneCnt_q  <= laneCnt_d;
            waitCnt_q  <= waitCnt_d;
            mData_q    <= mData_d;
`ifdef DOT_FEEDER_ACC_EN
            lastSeen_q <= lastSeen_d;
            acc_q      <= acc_d;
`endif
        end
    end

    // Next state. The wait counter is loaded with CORE_LAT on the closing
    // edge, so the sample happens on the edge where it still reads 1, which
    // is the CORE_LAT-th edge after the lanes were updated.
    always_comb begin
        state_d    = state_q;
        laneCnt_d  = laneCnt_q;
        waitCnt_d  = waitCnt_q;
        mData_d    = mData_q;
`ifdef DOT_FEEDER_ACC_EN
        lastSeen_d = lastSeen_q;
        acc_d      = acc_q;
`endif
        case (state_q)
            FILL: begin
                if (accepted) begin
                    laneCnt_d = laneCnt_q + LANE_IDX_W'(1);
                    if (closing) begin
                        state_d   = WAIT;
                        laneCnt_d = '0;
                        waitCnt_d = CW'(CORE_LAT);
`ifdef DOT_FEEDER_ACC_EN
                        lastSeen_d = bus.s_last_i;
`endif
                    end
                end
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - CW'(1);
                if (waitCnt_q == CW'(1)) begin
`ifdef DOT_FEEDER_ACC_EN
                    if (lastSeen_q) begin
                        mData_d = accSum;
                        acc_d   = '0;
                        state_d = OUT;
                    end else begin
                        acc_d   = accSum;
                        state_d = FILL;
                    end
`else
                    mData_d = sumW;
                    state_d = OUT;
`endif
                end
            end
            OUT: begin
                if (bus.m_ready_i) begin
                    state_d   = FILL;
                    laneCnt_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule
